// File: rtl/segway_pkg.sv
// Shared definitions for the segway UART blocks (receiver and transmitter).
package segway_pkg;

    // 19200 baud at a 50 MHz system clock
    localparam int unsigned BAUD_CYCLES_DFLT = 2604;
    localparam int unsigned DATA_BITS        = 8;

    // Serial framing states, common to UART_tx and the receiver
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Consumer-facing holding register contents
    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 rdy;
        logic                 frm_err;
        logic                 ovr_err;
    } rx_hold_t;

endpackage

// File: rtl/uart_rx_core.sv
// Bit-level UART receive framing: RX synchronizer, start detection, baud and
// bit counters, LSB-first shift register.
// Ports:
//   clk, rst_n    : system clock, asynchronous active-low reset
//   rx_i          : raw serial line (asynchronous, idles high)
//   byte_o        : assembled data byte (valid while byte_vld_c is high)
//   byte_vld_c    : one-cycle strobe, stop bit sampled high (combinational)
//   stop_bad_c    : one-cycle strobe, stop bit sampled low (combinational)
// BAUD_CYCLES must be at least 2 so the half-bit load is non-zero.
module uart_rx_core
    import segway_pkg::*;
#(
    parameter int unsigned BAUD_CYCLES = BAUD_CYCLES_DFLT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] byte_o,
    output logic                 byte_vld_c,
    output logic                 stop_bad_c
);

    localparam int unsigned       CNT_W    = $clog2(BAUD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BAUD_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(BAUD_CYCLES / 2);
    localparam logic [3:0]        LAST_BIT = 4'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;

    logic fall_c;
    logic expire_c;

    // Synchronized falling edge; a line held low never looks like a new edge
    assign fall_c   = rx_prev_q & ~rx_sync_q;
    // Counter is loaded with N and expires when it reaches 1, giving N clocks
    assign expire_c = (cnt_q == CNT_W'(1));
    assign byte_o   = shift_q;

    // State and datapath registers; synchronizer flops preset to line idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state, counters, shift and completion strobes
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_vld_c = 1'b0;
        stop_bad_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fall_c) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (expire_c) begin
                    if (!rx_sync_q) begin
                        state_d   = DATA;
                        cnt_d     = CNT_FULL;
                        bit_cnt_d = '0;
                    end else begin
                        // False start: glitch shorter than half a bit
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            DATA: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (expire_c) begin
                    shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    cnt_d     = CNT_FULL;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (expire_c) begin
                    byte_vld_c = rx_sync_q;
                    stop_bad_c = ~rx_sync_q;
                    state_d    = IDLE;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: framing core plus consumer holding register with
// ready handshake and sticky framing/overrun error flags.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   RX         : serial line from the BLE module (asynchronous, idles high)
//   clr_rdy    : consumer acknowledge; clears rdy, frm_err, ovr_err
//   rx_data    : last correctly framed byte
//   rdy        : rx_data holds an unconsumed byte
//   frm_err    : sticky, a stop bit was sampled low
//   ovr_err    : sticky, a byte completed while rdy was already high
module uart_cmd_rx
    import segway_pkg::*;
#(
    parameter int unsigned BAUD_CYCLES = BAUD_CYCLES_DFLT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 frm_err,
    output logic                 ovr_err
);

    logic [DATA_BITS-1:0] core_byte;
    logic                 core_vld_c;
    logic                 core_bad_c;

    rx_hold_t hold_q, hold_d;

    uart_rx_core #(
        .BAUD_CYCLES (BAUD_CYCLES)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (RX),
        .byte_o     (core_byte),
        .byte_vld_c (core_vld_c),
        .stop_bad_c (core_bad_c)
    );

    // Holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // Acknowledge clears first; a completion in the same cycle then wins, so a
    // byte arriving with clr_rdy keeps rdy high without flagging an overrun.
    always_comb begin
        hold_d = hold_q;
        if (clr_rdy) begin
            hold_d.rdy     = 1'b0;
            hold_d.frm_err = 1'b0;
            hold_d.ovr_err = 1'b0;
        end
        if (core_vld_c) begin
            hold_d.data = core_byte;
            hold_d.rdy  = 1'b1;
            if (hold_q.rdy && !clr_rdy) begin
                hold_d.ovr_err = 1'b1;
            end
        end
        if (core_bad_c) begin
            hold_d.frm_err = 1'b1;
        end
    end

    assign rx_data = hold_q.data;
    assign rdy     = hold_q.rdy;
    assign frm_err = hold_q.frm_err;
    assign ovr_err = hold_q.ovr_err;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: the stimulus thread drives serial frames
// and acknowledges, predicting the output tuple {rx_data,rdy,frm_err,ovr_err}
// from the receiver's rules; the monitor compares each observed change.
module tb_uart_cmd_rx;

    localparam int unsigned BAUD = 16;
    localparam int unsigned HALF = BAUD / 2;
    localparam int          LAT_MIN = 2 + (19 * BAUD) / 2 + 2 - 1;
    localparam int          LAT_MAX = 2 + (19 * BAUD) / 2 + 2 + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy, frm_err, ovr_err;

    always #5 clk = ~clk;

    uart_cmd_rx #(.BAUD_CYCLES(BAUD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .ovr_err (ovr_err)
    );

    typedef struct {
        logic [10:0] tup;
        int          start;
        bit          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model of the consumer-visible state
    logic [7:0] m_data = 8'h00;
    logic       m_rdy  = 1'b0;
    logic       m_frm  = 1'b0;
    logic       m_ovr  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [10:0] model_tup();
        return {m_data, m_rdy, m_frm, m_ovr};
    endfunction

    task automatic push_if_changed(input logic [10:0] old, input int start, input bit lat);
        exp_t e;
        if (model_tup() != old) begin
            e.tup = model_tup(); e.start = start; e.lat = lat;
            sb_q.push_back(e);
        end
    endtask

    task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit clr, input int start);
        logic [10:0] old;
        old = model_tup();
        if (stop_ok) begin
            m_data = d;
            if (clr) begin
                m_frm = 1'b0; m_ovr = 1'b0;
            end else if (m_rdy) begin
                m_ovr = 1'b1;
            end
            m_rdy = 1'b1;
        end else begin
            if (clr) begin
                m_rdy = 1'b0; m_ovr = 1'b0;
            end
            m_frm = 1'b1;
        end
        push_if_changed(old, start, 1'b1);
    endtask

    task automatic model_clear();
        logic [10:0] old;
        old = model_tup();
        m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
        push_if_changed(old, 0, 1'b0);
    endtask

    task automatic model_reset();
        logic [10:0] old;
        old = model_tup();
        m_data = 8'h00; m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
        push_if_changed(old, 0, 1'b0);
    endtask

    // One 8N1 frame; optional acknowledge landing on the completion clock,
    // optional reset at clock reset_k of the frame (-1 = none).
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit clr_done, input int reset_k);
        int start;
        int b;
        start = 0;
        for (int k = 0; k < int'(10 * BAUD); k++) begin
            @(negedge clk);
            if (k == 0) start = cyc;
            b = k / int'(BAUD);
            if (b == 0)      RX = 1'b0;
            else if (b <= 8) RX = d[b-1];
            else             RX = stop_ok;
            if (k == int'(9 * BAUD)) model_frame(d, stop_ok, clr_done, start);
            clr_rdy = (clr_done && k == int'(9 * BAUD + HALF + 2));
            if (k == reset_k) begin
                model_reset();
                rst_n = 1'b0;
                #1;
                checks++;
                if ({rx_data, rdy, frm_err, ovr_err} !== 11'h000) begin
                    errors++;
                    $display("FAIL reset_async: got %h want 000", {rx_data, rdy, frm_err, ovr_err});
                end
                RX = 1'b1;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                break;
            end
        end
        @(negedge clk);
        RX = 1'b1; clr_rdy = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clr();
        model_clear();
        @(negedge clk); clr_rdy = 1'b1;
        @(negedge clk); clr_rdy = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic glitch();
        @(negedge clk); RX = 1'b0;
        repeat (BAUD / 4) @(negedge clk);
        RX = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
    endtask

    // Monitor: every change of the output tuple must match the next prediction
    initial begin
        logic [10:0] prev, obs;
        exp_t e;
        int lat;
        prev = 11'h000;
        wait (rst_n === 1'b1);
        forever begin
            @(posedge clk); #1;
            obs = {rx_data, rdy, frm_err, ovr_err};
            if (obs !== prev) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %h, nothing predicted (cycle %0d)", obs, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (obs !== e.tup) begin
                        errors++;
                        $display("FAIL tuple: got data=%h rdy=%b frm=%b ovr=%b want data=%h rdy=%b frm=%b ovr=%b",
                                 obs[10:3], obs[2], obs[1], obs[0], e.tup[10:3], e.tup[2], e.tup[1], e.tup[0]);
                    end
                    if (e.lat) begin
                        checks++;
                        lat = cyc - e.start;
                        if (lat < LAT_MIN || lat > LAT_MAX) begin
                            errors++;
                            $display("FAIL latency: got %0d clocks want %0d..%0d", lat, LAT_MIN, LAT_MAX);
                        end
                    end
                end
                prev = obs;
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; RX = 1'b1; clr_rdy = 1'b0;
        #1 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({rx_data, rdy, frm_err, ovr_err} !== 11'h000) begin
            errors++;
            $display("FAIL reset_state: got %h want 000", {rx_data, rdy, frm_err, ovr_err});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'h67, 1'b1, 1'b0, -1);
        pulse_clr();

        send_frame(8'h73, 1'b1, 1'b0, -1);
        pulse_clr();
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        pulse_clr();

        send_frame(8'h55, 1'b1, 1'b0, -1);
        send_frame(8'hAA, 1'b1, 1'b0, -1);
        pulse_clr();

        send_frame(8'h3C, 1'b0, 1'b0, -1);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        pulse_clr();

        glitch();
        send_frame(8'h67, 1'b1, 1'b0, -1);

        // rdy already high: acknowledge coinciding with completion, no overrun
        send_frame(8'h5A, 1'b1, 1'b1, -1);

        // Reset during bit 4 of 0xFF, then a clean frame
        send_frame(8'hFF, 1'b1, 1'b0, int'(5 * BAUD + HALF));
        repeat (2 * BAUD) @(negedge clk);
        send_frame(8'h12, 1'b1, 1'b0, -1);
        pulse_clr();

        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            bit ok, cd;
            d  = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            cd = ok && ($urandom_range(0, 5) == 0);
            send_frame(d, ok, cd, -1);
            if ($urandom_range(0, 1) == 1) pulse_clr();
        end

        repeat (20) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL pending: %0d predicted changes never observed, want 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter BAUD_CYCLES, default 2604, meaning clocks per bit (19200 baud at 50 MHz).
REQ-002 SHALL have port clk, input, 1, the single system clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port RX, input, 1, serial line from the BLE module; idles high; asynchronous to clk.
REQ-005 SHALL have port clr_rdy, input, 1, consumer acknowledge; clears rdy and both error flags.
REQ-006 SHALL have port rx_data, output, 8, last correctly framed byte.
REQ-007 SHALL have port rdy, output, 1, rx_data holds an unconsumed byte.
REQ-008 SHALL have port frm_err, output, 1, sticky flag: stop bit sampled low.
REQ-009 SHALL have port ovr_err, output, 1, sticky flag: byte completed while rdy already high.

Function
REQ-010 SHALL pass RX through a two-flop synchronizer preset high; all decisions use the synchronized value.
REQ-011 SHALL detect a start bit only on a synchronized high-to-low transition in IDLE; a line held low never retriggers.
REQ-012 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-013 IDLE->START on detected falling edge; baud counter loads BAUD_CYCLES/2.
REQ-014 START at count expiry: line low -> DATA, counter loads BAUD_CYCLES; line high -> IDLE (false start), no flag change.
REQ-015 DATA SHALL sample 8 bits LSB first, one per BAUD_CYCLES expiry; a 4-bit bit counter tracks samples; after the 8th -> STOP.
REQ-016 STOP sample at mid stop bit: high -> frame valid; low -> frm_err set, byte discarded, rx_data/rdy unchanged; both -> IDLE.
REQ-017 On a valid frame, rx_data SHALL update and rdy SHALL assert on the clock after the stop-bit sample.
REQ-018 Valid frame completing while rdy=1 and clr_rdy=0: rx_data overwritten with new byte, ovr_err set, rdy stays 1.
REQ-019 Valid frame completing in the same cycle as clr_rdy=1: new byte loaded, rdy stays 1, ovr_err not set, errors cleared.
REQ-020 clr_rdy with no simultaneous completion SHALL clear rdy, frm_err, ovr_err next clock; rx_data holds.
REQ-021 Worst-case latency from RX falling edge to rdy SHALL be 2 + 9.5*BAUD_CYCLES + 2 clocks, +/-1 clock.
REQ-022 Baud counter width SHALL be ceil(log2(BAUD_CYCLES+1)); no wrap inside a bit period.

Reset
REQ-023 rst_n low SHALL asynchronously force: FSM IDLE, synchronizer flops 1, counters 0, shift reg 0, rx_data 8'h00, rdy 0, frm_err 0, ovr_err 0.
REQ-024 Reset mid-frame SHALL abandon the frame; after release, reception resumes only on a fresh falling edge.

Structure
REQ-025 State enum and default BAUD_CYCLES SHALL live in shared package segway_pkg, shared with UART_tx.
REQ-026 Bit-level framing (sync, FSM, counters, shift) SHALL be sub-module uart_rx_core with outputs byte[7:0], byte_vld, stop_bad; uart_cmd_rx adds holding register and flag logic.

Verification
REQ-027 UART_tx sends 8'h67 ('g') -> rdy rises within 9.5*BAUD_CYCLES+5 clocks of start edge, rx_data=8'h67, frm_err=0, ovr_err=0.
REQ-028 Send 8'h73, pulse clr_rdy after rdy, send 8'hA5 -> rdy deasserts then reasserts, rx_data=8'hA5, ovr_err=0.
REQ-029 Send 8'h55 and 8'hAA without clr_rdy -> rx_data=8'hAA, rdy=1, ovr_err=1; clr_rdy pulse -> all three clear.
REQ-030 Drive frame 8'h3C with stop bit low -> frm_err=1, rdy unchanged, rx_data unchanged; subsequent good 8'h3C -> rdy=1.
REQ-031 RX low pulse of BAUD_CYCLES/4 clocks -> no rdy, no frm_err, FSM back in IDLE; then 8'h67 received correctly.
REQ-032 Assert rst_n low at bit 4 of 8'hFF -> outputs zero immediately; after release, next 8'h12 received as 8'h12.
